// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, BUS_WIDTH data bits LSB first, optional
// parity bit, stop bit, one bit per baud-rate clock. Outputs are registered.
module uart_tx_serializer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Data_Valid,
  input  logic [BUS_WIDTH-1:0] P_DATA,
  input  logic                 PAR_EN,
  input  logic                 PAR_BIT,
  output logic                 TX_OUT,
  output logic                 Busy
);

  localparam int CNT_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BUS_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [BUS_WIDTH-1:0] shift, shift_next;
  logic                 par, par_next;
  logic                 par_en, par_en_next;
  logic                 tx_next;
  logic                 busy_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      shift  <= '0;
      par    <= 1'b0;
      par_en <= 1'b0;
      TX_OUT <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      shift  <= shift_next;
      par    <= par_next;
      par_en <= par_en_next;
      TX_OUT <= tx_next;
      Busy   <= busy_next;
    end
  end

  // tx_next/busy_next describe the line level for the cycle after this edge,
  // so every output is a pure register with no path from the inputs.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shift_next  = shift;
    par_next    = par;
    par_en_next = par_en;
    tx_next     = TX_OUT;
    busy_next   = Busy;

    unique case (state)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (Data_Valid) begin
          shift_next  = P_DATA;
          par_en_next = PAR_EN;
          cnt_next    = '0;
          state_next  = START;
          tx_next     = 1'b0;
          busy_next   = 1'b1;
        end
      end

      START: begin
        // The parity block registered PAR_BIT on the strobe edge; it is valid now.
        par_next   = PAR_BIT;
        state_next = DATA;
        tx_next    = shift[0];
      end

      DATA: begin
        shift_next = {1'b0, shift[BUS_WIDTH-1:1]};
        if (cnt == LAST_BIT) begin
          cnt_next = '0;
          if (par_en) begin
            state_next = PARITY;
            tx_next    = par;
          end else begin
            state_next = STOP;
            tx_next    = 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
          tx_next  = shift[1];
        end
      end

      PARITY: begin
        state_next = STOP;
        tx_next    = 1'b1;
      end

      STOP: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
